// File: rtl/alu_seq_cc.sv
// alu_seq_cc: registered execute-stage ALU with valid/ready handshake, iterative
// shift-add multiply and an architectural {ZF,SF,OF} condition-code register.
module alu_seq_cc #(
    parameter int W = 64,
    localparam int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         set_cc,
    output logic [W-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2:0]   cc
);
    typedef enum logic {IDLE, MUL_BUSY} state_t;
    state_t         state_q, state_d;
    logic [W-1:0]   out_q, out_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic           out_valid_q, out_valid_d, mset_q, mset_d;
    logic [2:0]     cc_q, cc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic           accept, load, load_set, load_of, alu_of;
    logic [W-1:0]   alu_r, acc_nx, load_r;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign cc        = cc_q;

    // MUL and the reserved encoding both yield zero here; MUL completes in the iterator.
    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        case (sel)
            3'b000: begin
                alu_r  = a + b;
                alu_of = (a[W-1] == b[W-1]) && (alu_r[W-1] != a[W-1]);
            end
            3'b001: begin
                alu_r  = a - b;
                alu_of = (a[W-1] != b[W-1]) && (alu_r[W-1] != a[W-1]);
            end
            3'b010:  alu_r = a & b;
            3'b011:  alu_r = a ^ b;
            3'b101:  alu_r = a << b[SHW-1:0];
            3'b110:  alu_r = $signed(a) >>> b[SHW-1:0];
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mset_d   = mset_q;
        load     = 1'b0;
        load_r   = alu_r;
        load_of  = alu_of;
        load_set = set_cc;
        if (state_q == MUL_BUSY) begin
            acc_d    = acc_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == SHW'(W - 1)) begin
                state_d  = IDLE;
                load     = 1'b1;
                load_r   = acc_nx;
                load_of  = 1'b0;
                load_set = mset_q;
            end
        end else if (accept && sel == 3'b100) begin
            state_d  = MUL_BUSY;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
            mset_d   = set_cc;
        end else if (accept) begin
            load = 1'b1;
        end
        out_d       = load ? load_r : out_q;
        out_valid_d = load || (out_valid_q && !out_ready);
        cc_d        = (load && load_set) ? {load_r == '0, load_r[W-1], load_of} : cc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            cc_q        <= 3'b000;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mset_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cc_q        <= cc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mset_q      <= mset_d;
        end
    end
endmodule

// File: tb/tb_alu_seq_cc.sv
// tb_alu_seq_cc: directed and randomized checks of alu_seq_cc against a
// transaction-level reference model.
module tb_alu_seq_cc;
    localparam int W = 64;
    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b1, set_cc = 1'b0;
    logic [2:0]   sel = 3'd0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out;
    logic [2:0]   cc;
    int           total = 0, bad = 0;
    bit           chk_en = 0;

    logic [W-1:0] m_out, p_r;
    logic         m_vld, p_set;
    logic [2:0]   m_cc;
    int           m_busy;

    alu_seq_cc #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .a(a), .b(b), .set_cc(set_cc), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .cc(cc)
    );

    always #5 clk = ~clk;

    // Returns {OF, result}; OF means the true signed value does not fit in W bits.
    function automatic logic [W:0] ref_op(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [W:0] wide;
        logic [W-1:0] r;
        logic of;
        r = '0;
        of = 1'b0;
        wide = '0;
        case (s)
            3'd0: begin wide = $signed({x[W-1], x}) + $signed({y[W-1], y}); r = wide[W-1:0]; of = wide != $signed({r[W-1], r}); end
            3'd1: begin wide = $signed({x[W-1], x}) - $signed({y[W-1], y}); r = wide[W-1:0]; of = wide != $signed({r[W-1], r}); end
            3'd2: r = x & y;
            3'd3: r = x ^ y;
            3'd4: r = x * y;
            3'd5: r = x << y[5:0];
            3'd6: r = $signed(x) >>> y[5:0];
            default: r = '0;
        endcase
        return {of, r};
    endfunction

    function automatic logic [W-1:0] rnd();
        case ($urandom % 6)
            0: return '0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    always @(posedge clk) begin : mdl
        logic ld, st, of;
        logic [W-1:0] r;
        logic [W:0] res;
        int busy;
        ld = 1'b0; st = 1'b0; of = 1'b0; r = '0; res = '0; busy = m_busy;
        if (rst) begin
            m_out <= '0; m_vld <= 1'b0; m_cc <= 3'b000; m_busy <= 0;
        end else begin
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin ld = 1'b1; r = p_r; st = p_set; end
            end else if (in_valid && (!m_vld || out_ready)) begin
                res = ref_op(sel, a, b);
                if (sel == 3'd4) begin busy = W; p_r <= res[W-1:0]; p_set <= set_cc; end
                else begin ld = 1'b1; r = res[W-1:0]; of = res[W]; st = set_cc; end
            end
            m_busy <= busy;
            m_vld  <= ld || (m_vld && !out_ready);
            if (ld) m_out <= r;
            if (ld && st) m_cc <= {r == '0, r[W-1], of};
        end
    end

    task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", n, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            chk("model_out", out, m_out);
            chk("model_out_valid", W'(out_valid), W'(m_vld));
            chk("model_cc", W'(cc), W'(m_cc));
            chk("model_in_ready", W'(in_ready), W'(m_busy == 0 && (!m_vld || out_ready)));
        end
    end

    task automatic issue(input logic [2:0] s, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; sel = s; a = x; b = y; set_cc = c;
        #1;
        while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
        total++;
        if (n >= 200) begin bad++; $display("FAIL issue_timeout: waited=%0d limit=200", n); end
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; set_cc = ~c;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        chk("pin_add", ref_op(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1), {1'b1, 64'h8000_0000_0000_0000});
        chk("pin_mul", ref_op(3'd4, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7), {1'b0, 64'hFFFF_FFFF_FFFF_FFEB});
        chk("pin_sar", ref_op(3'd6, 64'h8000_0000_0000_0000, 64'h43), {1'b0, 64'hF000_0000_0000_0000});
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        chk("rst_out", out, 0); chk("rst_vld", W'(out_valid), 0);
        chk("rst_cc", W'(cc), 0); chk("rst_rdy", W'(in_ready), 1);

        issue(3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        chk("add_out", out, 64'h8000_0000_0000_0000);
        chk("add_vld", W'(out_valid), 1); chk("add_cc", W'(cc), 3'b011);

        issue(3'd1, 64'd5, 64'd5, 1'b1);
        chk("sub_out", out, 0); chk("sub_cc", W'(cc), 3'b100);
        issue(3'd3, 64'hF0, 64'h0F, 1'b0);
        chk("xor_out", out, 64'hFF); chk("xor_cc", W'(cc), 3'b100);

        issue(3'd4, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b1);
        repeat (W - 1) @(posedge clk);
        #1;
        chk("mul_busy_rdy", W'(in_ready), 0); chk("mul_busy_vld", W'(out_valid), 0);
        @(posedge clk);
        #1;
        chk("mul_out", out, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_vld", W'(out_valid), 1); chk("mul_cc", W'(cc), 3'b010);

        issue(3'd6, 64'h8000_0000_0000_0000, 64'h43, 1'b0);
        chk("sar_out", out, 64'hF000_0000_0000_0000);
        issue(3'd5, 64'd1, 64'd63, 1'b0);
        chk("shl_out", out, 64'h8000_0000_0000_0000); chk("shl_cc", W'(cc), 3'b010);

        issue(3'd0, 64'd2, 64'd3, 1'b1);
        out_ready = 1'b0;
        chk("bp_out0", out, 64'd5); chk("bp_cc0", W'(cc), 3'b000);
        @(negedge clk);
        in_valid = 1'b1; sel = 3'd1; a = 64'd4; b = 64'd9; set_cc = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_hold_out", out, 64'd5); chk("bp_hold_vld", W'(out_valid), 1);
            chk("bp_hold_rdy", W'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", W'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_next_out", out, 64'hFFFF_FFFF_FFFF_FFFB); chk("bp_next_cc", W'(cc), 3'b010);

        issue(3'd7, 64'h1234, 64'h5678, 1'b1);
        chk("rsv_out", out, 0); chk("rsv_cc", W'(cc), 3'b100);

        issue(3'd4, 64'd3, 64'd5, 1'b1);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mrst_out", out, 0); chk("mrst_vld", W'(out_valid), 0);
        chk("mrst_cc", W'(cc), 0); chk("mrst_rdy", W'(in_ready), 1);
        repeat (W + 5) @(posedge clk);
        #1 chk("mrst_no_late", W'(out_valid), 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid  = ($urandom % 3) != 0;
            out_ready = ($urandom % 4) != 0;
            sel       = 3'($urandom % 8);
            a         = rnd();
            b         = ($urandom % 2) ? rnd() : W'($urandom % 70);
            set_cc    = 1'($urandom % 2);
            rst       = ($urandom % 600) == 0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (W + 10) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq_cc.md
# alu_seq_cc

Parametrised, registered successor to the combinational execute-stage ALU. Takes one operation per valid/ready handshake, performs add/sub/and/xor/shift in one cycle and an iterative multiply in W cycles, and registers the result. Maintains the architectural condition-code register {ZF,SF,OF}, which updates only on request. Sits in the execute stage of the sequential and pipelined processors, between operand select and the memory/writeback path.

## Interface
- W, 64: datapath width; power of two, ≥ 8.
- SHW, $clog2(W): shift-amount width; derived, not overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; transfer on in_valid && in_ready.
- sel  in  3  op: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 MUL, 101 SHL, 110 SAR, 111 reserved.
- a  in  W  operand A (signed).
- b  in  W  operand B (signed).
- set_cc  in  1  commit flags of this op to cc.
- out  out  W  registered result.
- out_valid  out  1  out holds an unconsumed result.
- out_ready  in  1  consumer takes result; transfer on out_valid && out_ready.
- cc  out  3  {ZF,SF,OF}: cc[2]=ZF, cc[1]=SF, cc[0]=OF.

## Operation
- FSM states: IDLE, MUL_BUSY.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- ADD: a+b mod 2^W; OF = (a[W-1]==b[W-1]) && (r[W-1]!=a[W-1]).
- SUB: a−b mod 2^W; OF = (a[W-1]!=b[W-1]) && (r[W-1]!=a[W-1]).
- AND, XOR: bitwise; OF=0.
- SHL: a << b[SHW-1:0]; SAR: arithmetic a >>> b[SHW-1:0]; upper bits of b ignored; OF=0.
- MUL: low W bits of a*b (identical for signed/unsigned); shift-add, one multiplier bit per cycle; OF=0.
- Reserved 111: result 0, OF=0, flags still computed (ZF=1).
- ZF = (r==0), SF = r[W-1], computed from the final W-bit result.
- cc loads {ZF,SF,OF} on the same edge that loads out, only if the accepted op had set_cc=1; otherwise cc unchanged.
- Operands, sel and set_cc are latched at acceptance; input changes afterward have no effect.

## Timing
- Reset (rst high at an edge): out=0, out_valid=0, cc=3'b000, state=IDLE, multiplier state cleared. In-flight MUL is abandoned; no cc update, no result.
- Single-cycle op accepted at edge n: out, out_valid=1 and cc (if set_cc) valid after edge n.
- Back-to-back: with out_ready=1, one single-cycle op accepted every cycle; out_valid stays high.
- MUL accepted at edge n: state=MUL_BUSY, in_ready=0 for W cycles; out/out_valid/cc updated at edge n+W; state returns to IDLE at that edge.
- out_valid && !out_ready: out, out_valid, cc held; in_ready=0.
- out_valid falls on the edge where out_ready=1 and no new op is accepted.
- Simultaneous out consume and new single-cycle accept: out replaced, out_valid stays 1.
- in_valid while in_ready=0: ignored, not queued.
- cc changes only on result-load edges or reset.

## Test plan
- Reset then ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1 -> one cycle later out=0x8000_0000_0000_0000, out_valid=1, cc=3'b011.
- SUB a=5, b=5, set_cc=1, then XOR a=0xF0, b=0x0F, set_cc=0 -> first out=0, cc=3'b100; second out=0xFF, cc stays 3'b100.
- MUL a=0xFFFF_FFFF_FFFF_FFFD (−3), b=7, set_cc=1 -> in_ready=0 for 64 cycles, out=0xFFFF_FFFF_FFFF_FFEB at acceptance+64, cc=3'b010.
- SAR a=0x8000_0000_0000_0000, b=0x43 (shift 3) -> out=0xF000_0000_0000_0000; SHL a=1, b=63 -> out=0x8000_0000_0000_0000.
- Back-pressure: ADD done, out_ready=0 for 5 cycles with in_valid=1 -> out/out_valid/cc held, in_ready=0, no ops accepted; out_ready=1 -> next op accepted that cycle.
- rst asserted 10 cycles into a MUL -> after that edge out=0, out_valid=0, cc=0, in_ready=1; no late result appears.
